// File: rtl/bit_serializer_piso_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding, default word width
// and the counter-width helper.
package bit_serializer_piso_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  localparam int SER_DEFAULT_WIDTH = 8;

  // Counter must hold 0..WIDTH inclusive.
  function automatic int ser_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bit_serializer_piso_bit_counter.sv
// Bit position counter for the serializer: sync clear, load-to-1, increment,
// and a flag raised while the final bit of a word is on the output.
module piso_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic load_one,
  input  logic inc,
  output logic is_last
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [CW-1:0] bit_cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      bit_cnt <= '0;
    end else if (load_one) begin
      bit_cnt <= CW'(1);
    end else if (inc) begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign is_last = (bit_cnt == LAST);

endmodule

// File: rtl/bit_serializer_piso.sv
// Parallel-in/serial-out stage: takes a word over valid/ready and emits one registered
// bit per clock, streaming back-to-back words with no idle bit in between.
module bit_serializer_piso
  import bit_serializer_piso_pkg::*;
#(
  parameter int WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output ser_state_e       state_dbg
);

  localparam int CW = ser_cnt_width(WIDTH);

  // Handshake: a word transfers on a posedge where load_valid && load_ready.
  // load_ready depends only on state and bit count, never on load_valid; the source
  // must hold load_valid/load_data stable until the transfer edge.

  ser_state_e       state, next_state;
  logic [WIDTH-1:0] shift_reg;
  logic             is_last;
  logic             last_bit;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= SER_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    last_bit   = (state == SER_SHIFT) && is_last;
    load_ready = (state == SER_IDLE) || last_bit;
    accept     = load_valid && load_ready;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (accept) begin
      next_state = SER_SHIFT;
    end else if (last_bit) begin
      next_state = SER_IDLE;
      cnt_clr    = 1'b1;
    end else if (state == SER_SHIFT) begin
      cnt_inc    = 1'b1;
    end
  end

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load_one (accept),
    .inc      (cnt_inc),
    .is_last  (is_last)
  );

  assign first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign next_bit  = MSB_FIRST ? shift_reg[WIDTH-2] : shift_reg[1];
  assign shifted   = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};

  // shift_reg keeps the not-yet-emitted bits aligned so the next bit is always at a fixed tap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg <= '0;
      x         <= IDLE_BIT;
    end else if (accept) begin
      shift_reg <= load_data;
      x         <= first_bit;
    end else if (cnt_inc) begin
      shift_reg <= shifted;
      x         <= next_bit;
    end else if (last_bit) begin
      x         <= IDLE_BIT;
    end
  end

  assign x_valid   = (state == SER_SHIFT);
  assign busy      = (state == SER_SHIFT);
  assign done      = last_bit;
  assign state_dbg = state;

endmodule

// File: tb/tb_bit_serializer_piso.sv
// Directed bench for bit_serializer_piso: MSB-first instance for most scenarios and an
// LSB-first instance for the bit-order case, with an expected-bit queue per stream.
module tb_bit_serializer_piso;
  import bit_serializer_piso_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid, load_valid2;
  logic [W-1:0] load_data, load_data2;
  logic         load_ready, x, x_valid, busy, done;
  logic         load_ready2, x2, x_valid2, busy2, done2;
  ser_state_e   state_dbg, state_dbg2;

  logic         exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_done;
  logic         e;

  always #5 clk = ~clk;

  bit_serializer_piso #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .x(x), .x_valid(x_valid), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  bit_serializer_piso #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid2), .load_data(load_data2),
    .load_ready(load_ready2), .x(x2), .x_valid(x_valid2), .busy(busy2), .done(done2),
    .state_dbg(state_dbg2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled at negedge; inputs are changed right after sampling.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [W-1:0] w, input bit msb_first);
    for (int i = 0; i < W; i++) exp_q.push_back(msb_first ? w[W-1-i] : w[i]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_xv"}, 32'(x_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rdy"}, 32'(load_ready), 32'd1);
    check({tag, "_st"}, 32'(state_dbg), 32'(SER_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_data = '0; load_valid2 = 1'b0; load_data2 = '0;

    // 1: reset then idle
    step(); step();
    reset = 1'b1;
    step();
    check_idle("t1");

    // 2: single word D0
    load_valid = 1'b1; load_data = 8'hD0; push_word(8'hD0, 1'b1);
    n_done = 0;
    for (int i = 0; i < W; i++) begin
      step();
      e = exp_q.pop_front();
      check("t2_bit", 32'(x), 32'(e));
      check("t2_done", 32'(done), 32'(i == W - 1));
      check("t2_xv", 32'(x_valid), 32'd1);
      n_done += int'(done);
      if (i == 0) load_valid = 1'b0;
    end
    check("t2_ndone", 32'(n_done), 32'd1);
    step();
    check_idle("t2_end");

    // 3: back-to-back DD then B6 with load_valid held
    load_valid = 1'b1; load_data = 8'hDD; push_word(8'hDD, 1'b1); push_word(8'hB6, 1'b1);
    n_done = 0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      e = exp_q.pop_front();
      check("t3_bit", 32'(x), 32'(e));
      check("t3_rdy", 32'(load_ready), 32'(i == W - 1 || i == 2 * W - 1));
      check("t3_busy", 32'(busy), 32'd1);
      n_done += int'(done);
      if (i == 0) load_data = 8'hB6;
      if (i == W) load_valid = 1'b0;
    end
    check("t3_ndone", 32'(n_done), 32'd2);
    step();
    check_idle("t3_end");

    // 4: FF presented on cycles 3..6 of D0 is ignored
    load_valid = 1'b1; load_data = 8'hD0; push_word(8'hD0, 1'b1);
    for (int i = 0; i < W; i++) begin
      step();
      e = exp_q.pop_front();
      check("t4_bit", 32'(x), 32'(e));
      if (i >= 2 && i <= 5) check("t4_rdy", 32'(load_ready), 32'd0);
      load_valid = (i >= 1 && i <= 4);
      load_data  = (i >= 1 && i <= 4) ? 8'hFF : 8'hD0;
    end
    step();
    check_idle("t4_end");

    // 5: reset on the 4th bit, with a load presented in the reset cycle
    load_valid = 1'b1; load_data = 8'hD0; push_word(8'hD0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      e = exp_q.pop_front();
      check("t5_bit", 32'(x), 32'(e));
      load_valid = 1'b0;
    end
    check("t5_done_pre", 32'(done), 32'd0);
    exp_q.delete();
    reset = 1'b0; load_valid = 1'b1; load_data = 8'hFF;
    step();
    check_idle("t5_rst");
    reset = 1'b1; load_valid = 1'b0;
    step();
    check_idle("t5_after");
    load_valid = 1'b1; load_data = 8'h3C; push_word(8'h3C, 1'b1);
    n_done = 0;
    for (int i = 0; i < W; i++) begin
      step();
      e = exp_q.pop_front();
      check("t5_bit2", 32'(x), 32'(e));
      n_done += int'(done);
      load_valid = 1'b0;
    end
    check("t5_ndone", 32'(n_done), 32'd1);

    // 6: LSB-first instance, 0B -> 1,1,0,1,0,0,0,0
    step();
    check("t6_rdy0", 32'(load_ready2), 32'd1);
    check("t6_x0", 32'(x2), 32'd0);
    load_valid2 = 1'b1; load_data2 = 8'h0B; push_word(8'h0B, 1'b0);
    for (int i = 0; i < W; i++) begin
      step();
      e = exp_q.pop_front();
      check("t6_bit", 32'(x2), 32'(e));
      check("t6_done", 32'(done2), 32'(i == W - 1));
      load_valid2 = 1'b0;
    end
    step();
    check("t6_xv_end", 32'(x_valid2), 32'd0);
    check("t6_busy_end", 32'(busy2), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
